// File: rtl/nor_cmd_pkg.sv
// Shared definitions for the NOR command sequencer: operation codes, JEDEC
// unlock addresses and command bytes, per-operation step tables.
package nor_cmd_pkg;

  typedef enum logic [1:0] {
    OP_READ         = 2'd0,
    OP_PROGRAM      = 2'd1,
    OP_SECTOR_ERASE = 2'd2,
    OP_RESET        = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XFER   = 3'd1,  // command-table step in flight (issue + wait for ack)
    S_POLL_A = 3'd2,  // first status read of a toggle pair in flight
    S_POLL_B = 3'd3,  // second status read of a toggle pair in flight
    S_RESP   = 3'd4
  } seq_state_e;

  localparam logic [11:0] UNLOCK_ADR_1 = 12'h555;
  localparam logic [11:0] UNLOCK_ADR_2 = 12'h2AA;
  localparam logic [11:0] RESET_ADR    = 12'h000;

  localparam logic [7:0] CMD_UNLOCK_1     = 8'hAA;
  localparam logic [7:0] CMD_UNLOCK_2     = 8'h55;
  localparam logic [7:0] CMD_PROGRAM      = 8'hA0;
  localparam logic [7:0] CMD_ERASE_SETUP  = 8'h80;
  localparam logic [7:0] CMD_SECTOR_ERASE = 8'h30;
  localparam logic [7:0] CMD_RESET        = 8'hF0;

  localparam logic [2:0] STEPS_READ    = 3'd1;
  localparam logic [2:0] STEPS_PROGRAM = 3'd4;
  localparam logic [2:0] STEPS_ERASE   = 3'd6;
  localparam logic [2:0] STEPS_RESET   = 3'd1;

  // DQ6 toggles on every status read while an embedded algorithm runs.
  localparam int DQ6_BIT = 6;

  // One bus transaction of a command sequence. Address/data either come
  // from a fixed unlock/command value or from the latched command fields.
  typedef struct packed {
    logic        we;
    logic        use_target_adr;
    logic [11:0] fixed_adr;
    logic        use_cmd_data;
    logic [7:0]  cmd_byte;
  } step_t;

  function automatic step_t fixed_write(input logic [11:0] adr, input logic [7:0] cmd);
    step_t s;
    s.we             = 1'b1;
    s.use_target_adr = 1'b0;
    s.fixed_adr      = adr;
    s.use_cmd_data   = 1'b0;
    s.cmd_byte       = cmd;
    return s;
  endfunction

  function automatic step_t target_access(input logic we, input logic use_data,
                                          input logic [7:0] cmd);
    step_t s;
    s.we             = we;
    s.use_target_adr = 1'b1;
    s.fixed_adr      = 12'h000;
    s.use_cmd_data   = use_data;
    s.cmd_byte       = cmd;
    return s;
  endfunction

  function automatic logic [2:0] step_count(input op_e op);
    logic [2:0] n;
    case (op)
      OP_READ:         n = STEPS_READ;
      OP_PROGRAM:      n = STEPS_PROGRAM;
      OP_SECTOR_ERASE: n = STEPS_ERASE;
      OP_RESET:        n = STEPS_RESET;
      default:         n = 3'd1;
    endcase
    return n;
  endfunction

  function automatic logic op_polls(input op_e op);
    return (op == OP_PROGRAM) || (op == OP_SECTOR_ERASE);
  endfunction

  function automatic step_t step_lookup(input op_e op, input logic [2:0] idx);
    step_t s;
    s = target_access(1'b0, 1'b0, 8'h00);
    case (op)
      OP_READ: s = target_access(1'b0, 1'b0, 8'h00);
      OP_PROGRAM: begin
        case (idx)
          3'd0:    s = fixed_write(UNLOCK_ADR_1, CMD_UNLOCK_1);
          3'd1:    s = fixed_write(UNLOCK_ADR_2, CMD_UNLOCK_2);
          3'd2:    s = fixed_write(UNLOCK_ADR_1, CMD_PROGRAM);
          3'd3:    s = target_access(1'b1, 1'b1, 8'h00);
          default: s = fixed_write(RESET_ADR, CMD_RESET);
        endcase
      end
      OP_SECTOR_ERASE: begin
        case (idx)
          3'd0:    s = fixed_write(UNLOCK_ADR_1, CMD_UNLOCK_1);
          3'd1:    s = fixed_write(UNLOCK_ADR_2, CMD_UNLOCK_2);
          3'd2:    s = fixed_write(UNLOCK_ADR_1, CMD_ERASE_SETUP);
          3'd3:    s = fixed_write(UNLOCK_ADR_1, CMD_UNLOCK_1);
          3'd4:    s = fixed_write(UNLOCK_ADR_2, CMD_UNLOCK_2);
          3'd5:    s = target_access(1'b1, 1'b0, CMD_SECTOR_ERASE);
          default: s = fixed_write(RESET_ADR, CMD_RESET);
        endcase
      end
      OP_RESET: s = fixed_write(RESET_ADR, CMD_RESET);
      default:  s = fixed_write(RESET_ADR, CMD_RESET);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wb_txn_master.sv
// Single-transaction wishbone engine. A one-cycle request loads address,
// data and direction and raises stb; stb drops once the slave stops
// stalling. Completion (ack or err) is reported combinationally in the cycle
// it arrives, so the owner can launch the next request on the same edge.
module wb_txn_master
  #(
    parameter int ADDRBITS = 26,
    parameter int DATABITS = 16
  )
  (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req,
    input  logic                i_we,
    input  logic [ADDRBITS-1:0] i_adr,
    input  logic [DATABITS-1:0] i_dat,
    output logic                o_done,
    output logic                o_err,
    output logic [DATABITS-1:0] o_rdata,
    output logic                o_stb,
    output logic                o_we,
    output logic [ADDRBITS-1:0] o_adr,
    output logic [DATABITS-1:0] o_dat,
    input  logic                i_ack,
    input  logic                i_err,
    input  logic                i_stall,
    input  logic [DATABITS-1:0] i_rdata
  );

  logic                r_busy;
  logic                r_stb;
  logic                r_we;
  logic [ADDRBITS-1:0] r_adr;
  logic [DATABITS-1:0] r_dat;

  // An ack that lands while stb is still high (stall just dropped) still
  // belongs to this transaction; responses outside a transaction are ignored.
  assign o_done  = r_busy & (i_ack | i_err);
  assign o_err   = r_busy & i_err;
  assign o_rdata = i_rdata;
  assign o_stb   = r_stb;
  assign o_we    = r_we;
  assign o_adr   = r_adr;
  assign o_dat   = r_dat;

  // Transaction state: load on request, hold stb through stall, retire on ack/err.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_stb  <= 1'b0;
      r_we   <= 1'b0;
      r_adr  <= {ADDRBITS{1'b0}};
      r_dat  <= {DATABITS{1'b0}};
    end else if (i_req) begin
      r_busy <= 1'b1;
      r_stb  <= 1'b1;
      r_we   <= i_we;
      r_adr  <= i_adr;
      r_dat  <= i_dat;
    end else if (o_done) begin
      r_busy <= 1'b0;
      r_stb  <= 1'b0;
    end else if (r_stb && !i_stall) begin
      r_stb <= 1'b0;
    end
  end

endmodule

// File: rtl/nor_cmd_seq.sv
// NOR command sequencer: expands READ / PROGRAM / SECTOR_ERASE / RESET into
// JEDEC unlock+command write sequences on a wishbone master port, polls the
// DQ6 toggle bit after program/erase, and returns one response per command.
module nor_cmd_seq
  import nor_cmd_pkg::*;
  #(
    parameter int ADDRBITS   = 26,
    parameter int DATABITS   = 16,
    parameter int POLL_LIMIT = 1000000
  )
  (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [ADDRBITS-1:0] cmd_addr_i,
    input  logic [DATABITS-1:0] cmd_data_i,
    output logic                rsp_valid_o,
    output logic [DATABITS-1:0] rsp_data_o,
    output logic                rsp_err_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDRBITS-1:0] wb_adr_o,
    output logic [DATABITS-1:0] wb_dat_o,
    input  logic [DATABITS-1:0] wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_stall_i
  );

  localparam int             PCW          = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_LIMIT_C = PCW'(POLL_LIMIT);

  seq_state_e          r_state;
  op_e                 r_op;
  logic [ADDRBITS-1:0] r_addr;
  logic [DATABITS-1:0] r_data;
  logic [2:0]          r_step;
  logic [PCW-1:0]      r_poll_cnt;
  logic [DATABITS-1:0] r_first_rd;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DATABITS-1:0] r_rsp_data;
  logic                r_rsp_err;
  logic                r_cyc;

  op_e                 w_src_op;
  logic [ADDRBITS-1:0] w_src_addr;
  logic [DATABITS-1:0] w_src_data;
  logic [2:0]          w_step_idx;
  step_t               w_step;
  logic                w_more_steps;
  logic                w_toggled;
  logic [PCW-1:0]      w_poll_next;
  logic                w_timeout;
  logic                w_req_cmd;
  logic                w_req_poll;
  logic                w_req;
  logic                w_req_we;
  logic [ADDRBITS-1:0] w_req_adr;
  logic [DATABITS-1:0] w_req_dat;
  logic                w_done;
  logic                w_err;
  logic [DATABITS-1:0] w_rdata;

  // Step source: the first step is launched on the accept edge straight from
  // the command port so stb rises the cycle after acceptance.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_src_op   = op_e'(cmd_op_i);
      w_src_addr = cmd_addr_i;
      w_src_data = cmd_data_i;
      w_step_idx = 3'd0;
    end else begin
      w_src_op   = r_op;
      w_src_addr = r_addr;
      w_src_data = r_data;
      w_step_idx = r_step + 3'd1;
    end
  end

  assign w_step       = step_lookup(w_src_op, w_step_idx);
  assign w_more_steps = (r_step + 3'd1) < step_count(r_op);
  assign w_toggled    = w_rdata[DQ6_BIT] != r_first_rd[DQ6_BIT];
  assign w_poll_next  = r_poll_cnt + {{(PCW-1){1'b0}}, 1'b1};
  assign w_timeout    = w_poll_next >= POLL_LIMIT_C;

  // Decide whether this cycle launches the next table step or a status read.
  always_comb begin
    w_req_cmd  = 1'b0;
    w_req_poll = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_cmd = cmd_valid_i;
      end
      S_XFER: begin
        if (w_done && !w_err) begin
          if (w_more_steps) begin
            w_req_cmd = 1'b1;
          end else begin
            w_req_poll = op_polls(r_op);
          end
        end else begin
          w_req_cmd = 1'b0;
        end
      end
      S_POLL_A: begin
        if (w_done && !w_err) begin
          w_req_poll = 1'b1;
        end else begin
          w_req_poll = 1'b0;
        end
      end
      S_POLL_B: begin
        if (w_done && !w_err && w_toggled && !w_timeout) begin
          w_req_poll = 1'b1;
        end else begin
          w_req_poll = 1'b0;
        end
      end
      default: begin
        w_req_cmd  = 1'b0;
        w_req_poll = 1'b0;
      end
    endcase
  end

  assign w_req     = w_req_cmd | w_req_poll;
  assign w_req_we  = w_req_cmd & w_step.we;
  assign w_req_adr = (w_req_poll || w_step.use_target_adr) ? w_src_addr
                                                           : ADDRBITS'(w_step.fixed_adr);
  assign w_req_dat = w_req_poll ? {DATABITS{1'b0}}
                   : (w_step.use_cmd_data ? w_src_data : DATABITS'(w_step.cmd_byte));

  wb_txn_master #(
    .ADDRBITS (ADDRBITS),
    .DATABITS (DATABITS)
  ) u_txn (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_req   (w_req),
    .i_we    (w_req_we),
    .i_adr   (w_req_adr),
    .i_dat   (w_req_dat),
    .o_done  (w_done),
    .o_err   (w_err),
    .o_rdata (w_rdata),
    .o_stb   (wb_stb_o),
    .o_we    (wb_we_o),
    .o_adr   (wb_adr_o),
    .o_dat   (wb_dat_o),
    .i_ack   (wb_ack_i),
    .i_err   (wb_err_i),
    .i_stall (wb_stall_i),
    .i_rdata (wb_dat_i)
  );

  // Sequencer FSM: owns cyc for the whole command (polls included) and the
  // registered response / ready outputs. Entering RESP always drops cyc.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_op        <= OP_READ;
      r_addr      <= {ADDRBITS{1'b0}};
      r_data      <= {DATABITS{1'b0}};
      r_step      <= 3'd0;
      r_poll_cnt  <= {PCW{1'b0}};
      r_first_rd  <= {DATABITS{1'b0}};
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {DATABITS{1'b0}};
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_op        <= op_e'(cmd_op_i);
            r_addr      <= cmd_addr_i;
            r_data      <= cmd_data_i;
            r_step      <= 3'd0;
            r_poll_cnt  <= {PCW{1'b0}};
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_done) begin
            if (w_err) begin
              r_state <= S_RESP; r_cyc <= 1'b0; r_rsp_valid <= 1'b1;
              r_rsp_err <= 1'b1; r_rsp_data <= {DATABITS{1'b0}};
            end else if (w_more_steps) begin
              r_step <= r_step + 3'd1;
            end else if (op_polls(r_op)) begin
              r_state <= S_POLL_A;
            end else begin
              r_state <= S_RESP; r_cyc <= 1'b0; r_rsp_valid <= 1'b1;
              r_rsp_err  <= 1'b0;
              r_rsp_data <= (r_op == OP_READ) ? w_rdata : {DATABITS{1'b0}};
            end
          end
        end
        S_POLL_A: begin
          if (w_done) begin
            if (w_err) begin
              r_state <= S_RESP; r_cyc <= 1'b0; r_rsp_valid <= 1'b1;
              r_rsp_err <= 1'b1; r_rsp_data <= {DATABITS{1'b0}};
            end else begin
              r_first_rd <= w_rdata;
              r_state    <= S_POLL_B;
            end
          end
        end
        S_POLL_B: begin
          if (w_done) begin
            if (w_err) begin
              r_state <= S_RESP; r_cyc <= 1'b0; r_rsp_valid <= 1'b1;
              r_rsp_err <= 1'b1; r_rsp_data <= {DATABITS{1'b0}};
            end else if (!w_toggled) begin
              r_state <= S_RESP; r_cyc <= 1'b0; r_rsp_valid <= 1'b1;
              r_rsp_err <= 1'b0; r_rsp_data <= w_rdata;
            end else if (w_timeout) begin
              // Timeout still reports the last status word for diagnosis.
              r_state <= S_RESP; r_cyc <= 1'b0; r_rsp_valid <= 1'b1;
              r_rsp_err <= 1'b1; r_rsp_data <= w_rdata;
            end else begin
              r_poll_cnt <= w_poll_next;
              r_state    <= S_POLL_A;
            end
          end
        end
        S_RESP: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_cyc       <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
  assign wb_cyc_o    = r_cyc;

endmodule

// File: tb/tb_nor_cmd_seq.sv
// Scoreboard bench for nor_cmd_seq: expected bus transactions and responses
// are queued when a command is issued; a slave/monitor process compares.
module tb_nor_cmd_seq;

  localparam int AB = 26;
  localparam int DB = 16;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [AB-1:0] cmd_addr_i;
  logic [DB-1:0] cmd_data_i;
  logic          rsp_valid_o;
  logic [DB-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AB-1:0] wb_adr_o;
  logic [DB-1:0] wb_dat_o;
  logic [DB-1:0] wb_dat_i;
  logic          wb_ack_i, wb_err_i, wb_stall_i;

  nor_cmd_seq #(.ADDRBITS(AB), .DATABITS(DB), .POLL_LIMIT(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct { logic we; logic [AB-1:0] adr; logic [DB-1:0] dat; } txn_t;
  typedef struct { logic [DB-1:0] dat; logic err; } rsp_t;

  txn_t          exp_txn_q[$];
  rsp_t          exp_rsp_q[$];
  logic [DB-1:0] rd_q[$];

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int stall_cfg = 0;
  bit same_cycle_ack = 1'b0;
  int err_at = -1;
  int txn_idx = 0;
  int txn_seen = 0;
  int rsp_seen = 0;
  int last_ack_cyc = 0;
  int cyc_drops = 0;

  // slave-side state
  bit            s_pend = 1'b0;
  bit            s_in_txn = 1'b0;
  int            s_stall_left = 0;
  logic          s_we = 1'b0;
  logic [AB-1:0] s_adr = '0;
  logic [DB-1:0] s_dat = '0;
  logic          prev_cyc = 1'b0;
  bit            chk_ready_next = 1'b0;

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_txn(input logic we, input logic [AB-1:0] adr, input logic [DB-1:0] dat);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat;
    exp_txn_q.push_back(t);
  endtask

  task automatic push_rsp(input logic [DB-1:0] dat, input logic err);
    rsp_t r;
    r.dat = dat; r.err = err;
    exp_rsp_q.push_back(r);
  endtask

  // Slave answer for the transaction captured in s_we.
  task automatic respond();
    if (txn_idx == err_at) begin
      wb_err_i = 1'b1;
    end else begin
      wb_ack_i = 1'b1;
      if (!s_we && rd_q.size() > 0) wb_dat_i = rd_q.pop_front();
    end
    txn_idx++;
    last_ack_cyc = cyc_n;
  endtask

  task automatic record_txn();
    txn_t t;
    txn_seen++;
    if (exp_txn_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL txn_unexpected actual we=%0d adr=0x%0h dat=0x%0h required=none",
               wb_we_o, wb_adr_o, wb_dat_o);
    end else begin
      t = exp_txn_q.pop_front();
      chk("txn_we", {31'd0, wb_we_o}, {31'd0, t.we});
      chk("txn_adr", {6'd0, wb_adr_o}, {6'd0, t.adr});
      if (t.we) chk("txn_dat", {16'd0, wb_dat_o}, {16'd0, t.dat});
    end
  endtask

  task automatic check_rsp();
    rsp_t r;
    rsp_seen++;
    chk("rsp_latency", cyc_n, last_ack_cyc + 1);
    chk("rsp_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    chk("rsp_ready_low", {31'd0, cmd_ready_o}, 32'd0);
    chk("cyc_drops", cyc_drops, 32'd0);
    if (exp_rsp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL rsp_unexpected actual data=0x%0h err=%0d required=none", rsp_data_o, rsp_err_o);
    end else begin
      r = exp_rsp_q.pop_front();
      chk("rsp_data", {16'd0, rsp_data_o}, {16'd0, r.dat});
      chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, r.err});
    end
    chk_ready_next = 1'b1;
  endtask

  // Wishbone slave and output monitor, evaluated on the falling edge.
  initial begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
    forever begin
      @(negedge wb_clk_i);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
      if (wb_rst_i) begin
        s_pend = 1'b0; s_in_txn = 1'b0; prev_cyc = 1'b0; chk_ready_next = 1'b0;
      end else begin
        if (chk_ready_next) begin
          chk("ready_after_rsp", {31'd0, cmd_ready_o}, 32'd1);
          chk("rsp_one_cycle", {31'd0, rsp_valid_o}, 32'd0);
          chk_ready_next = 1'b0;
        end
        if (prev_cyc && !wb_cyc_o && !rsp_valid_o) cyc_drops++;
        prev_cyc = wb_cyc_o;
        if (s_pend) begin
          respond();
          s_pend = 1'b0;
        end else if (wb_stb_o) begin
          chk("stb_in_cyc", {31'd0, wb_cyc_o}, 32'd1);
          if (!s_in_txn) begin
            s_in_txn = 1'b1; s_stall_left = stall_cfg;
            s_we = wb_we_o; s_adr = wb_adr_o; s_dat = wb_dat_o;
          end else begin
            chk("stall_hold_adr", {6'd0, wb_adr_o}, {6'd0, s_adr});
            chk("stall_hold_dat", {16'd0, wb_dat_o}, {16'd0, s_dat});
            chk("stall_hold_we", {31'd0, wb_we_o}, {31'd0, s_we});
          end
          if (s_stall_left > 0) begin
            wb_stall_i = 1'b1;
            s_stall_left--;
          end else begin
            s_in_txn = 1'b0;
            record_txn();
            if (same_cycle_ack) respond();
            else s_pend = 1'b1;
          end
        end
        if (rsp_valid_o) check_rsp();
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [AB-1:0] adr, input logic [DB-1:0] dat);
    int n;
    n = 0;
    txn_idx = 0;
    @(negedge wb_clk_i);
    while (!cmd_ready_o && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = adr; cmd_data_i = dat;
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
    chk("accept_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("accept_stb", {31'd0, wb_stb_o}, 32'd1);
  endtask

  task automatic wait_rsp();
    int n;
    int base;
    n = 0;
    base = rsp_seen;
    while (rsp_seen < base + 1 && n < 400) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("rsp_arrived", rsp_seen - base, 32'd1);
    repeat (4) @(negedge wb_clk_i);
    chk("txn_left", exp_txn_q.size(), 32'd0);
    chk("rsp_left", exp_rsp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    wb_rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_addr_i = '0; cmd_data_i = '0;
    repeat (2) @(negedge wb_clk_i);
    chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data_o}, 32'd0);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_adr", {6'd0, wb_adr_o}, 32'd0);
    chk("rst_dat", {16'd0, wb_dat_o}, 32'd0);
    wb_rst_i = 1'b0;

    // READ with three stall cycles
    stall_cfg = 3;
    rd_q.push_back(16'hBEEF);
    push_txn(1'b0, 26'h0001234, 16'h0000);
    push_rsp(16'hBEEF, 1'b0);
    send_cmd(2'd0, 26'h0001234, 16'h0000);
    wait_rsp();

    // PROGRAM: three toggling pairs then a stable pair
    stall_cfg = 1;
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(16'h0040); rd_q.push_back(16'h0000);
    end
    rd_q.push_back(16'h5A5A); rd_q.push_back(16'h5A5A);
    push_txn(1'b1, 26'h555, 16'h00AA);
    push_txn(1'b1, 26'h2AA, 16'h0055);
    push_txn(1'b1, 26'h555, 16'h00A0);
    push_txn(1'b1, 26'h010, 16'h5A5A);
    for (int i = 0; i < 8; i++) push_txn(1'b0, 26'h010, 16'h0000);
    push_rsp(16'h5A5A, 1'b0);
    send_cmd(2'd1, 26'h010, 16'h5A5A);
    wait_rsp();

    // SECTOR_ERASE: one toggling pair then stable
    stall_cfg = 0;
    rd_q.push_back(16'h0000); rd_q.push_back(16'h0040);
    rd_q.push_back(16'hFFFF); rd_q.push_back(16'hFFFF);
    push_txn(1'b1, 26'h555, 16'h00AA);
    push_txn(1'b1, 26'h2AA, 16'h0055);
    push_txn(1'b1, 26'h555, 16'h0080);
    push_txn(1'b1, 26'h555, 16'h00AA);
    push_txn(1'b1, 26'h2AA, 16'h0055);
    push_txn(1'b1, 26'h20000, 16'h0030);
    for (int i = 0; i < 4; i++) push_txn(1'b0, 26'h20000, 16'h0000);
    push_rsp(16'hFFFF, 1'b0);
    send_cmd(2'd2, 26'h20000, 16'h0000);
    wait_rsp();

    // PROGRAM timeout: DQ6 toggles on every read, limit of 4 pairs
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(16'h00C3); rd_q.push_back(16'h0083);
    end
    push_txn(1'b1, 26'h555, 16'h00AA);
    push_txn(1'b1, 26'h2AA, 16'h0055);
    push_txn(1'b1, 26'h555, 16'h00A0);
    push_txn(1'b1, 26'h033, 16'h1234);
    for (int i = 0; i < 8; i++) push_txn(1'b0, 26'h033, 16'h0000);
    push_rsp(16'h0083, 1'b1);
    send_cmd(2'd1, 26'h033, 16'h1234);
    wait_rsp();

    // Bus error on the second unlock write abandons the sequence
    err_at = 1;
    push_txn(1'b1, 26'h555, 16'h00AA);
    push_txn(1'b1, 26'h2AA, 16'h0055);
    push_rsp(16'h0000, 1'b1);
    send_cmd(2'd1, 26'h040, 16'h1111);
    wait_rsp();
    err_at = -1;

    // Reset asserted during polling
    for (int i = 0; i < 10; i++) begin
      rd_q.push_back(16'h0040); rd_q.push_back(16'h0000);
    end
    push_txn(1'b1, 26'h555, 16'h00AA);
    push_txn(1'b1, 26'h2AA, 16'h0055);
    push_txn(1'b1, 26'h555, 16'h00A0);
    push_txn(1'b1, 26'h050, 16'h2222);
    push_txn(1'b0, 26'h050, 16'h0000);
    push_txn(1'b0, 26'h050, 16'h0000);
    base = txn_seen;
    send_cmd(2'd1, 26'h050, 16'h2222);
    n = 0;
    while (txn_seen < base + 6 && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("poll_reached", txn_seen - base, 32'd6);
    @(posedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("midrst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("midrst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("midrst_we", {31'd0, wb_we_o}, 32'd0);
    chk("midrst_adr", {6'd0, wb_adr_o}, 32'd0);
    exp_txn_q.delete();
    rd_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // RESET command, slave acks in the same cycle stall is low
    same_cycle_ack = 1'b1;
    push_txn(1'b1, 26'h000, 16'h00F0);
    push_rsp(16'h0000, 1'b0);
    send_cmd(2'd3, 26'h0ABCD, 16'h9999);
    wait_rsp();
    same_cycle_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nor_cmd_seq.md
# nor_cmd_seq

Command sequencer sitting directly upstream of the parallel NOR wishbone bus block. It accepts high-level flash operations (read, word program, sector erase, reset) on a valid/ready command port. It expands each operation into the JEDEC unlock/command write sequence as single wishbone master transactions. For program and erase it then polls DQ6 toggle status until the device finishes or a poll limit expires, and returns one response per command.

## Interface
- ADDRBITS, 26, word address width (matches downstream NOR bus)
- DATABITS, 16, data width
- POLL_LIMIT, 1000000, max toggle-poll read pairs before timeout
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_op_i  in  2  0=READ, 1=PROGRAM, 2=SECTOR_ERASE, 3=RESET
- cmd_addr_i  in  ADDRBITS  target word / sector address
- cmd_data_i  in  DATABITS  program data
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_data_o  out  DATABITS  read data (READ), last status read (PROGRAM/ERASE), 0 otherwise
- rsp_err_o  out  1  valid with rsp_valid_o: wb_err_i seen or poll timeout
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  wishbone master controls
- wb_adr_o  out  ADDRBITS; wb_dat_o  out  DATABITS
- wb_dat_i  in  DATABITS; wb_ack_i, wb_err_i, wb_stall_i  in  1

## Operation
- Step lists (addr/data writes unless noted):
  - READ: read cmd_addr.
  - PROGRAM: 555/AA, 2AA/55, 555/A0, cmd_addr/cmd_data, then poll.
  - SECTOR_ERASE: 555/AA, 2AA/55, 555/80, 555/AA, 2AA/55, cmd_addr/30, then poll.
  - RESET: 000/F0.
- States: IDLE → ISSUE → WAIT_ACK → (next step: ISSUE | poll: POLL_A | done: RESP) ; POLL_A → POLL_B → (toggle: POLL_A | stable: RESP) ; RESP → IDLE.
- IDLE: cmd_ready_o=1; on accept latch op/addr/data, clear step index and poll counter, go ISSUE.
- ISSUE: stb=1 with step addr/data/we; leave when !wb_stall_i.
- WAIT_ACK: stb=0, cyc=1; on wb_ack_i capture wb_dat_i, advance step. Exactly one transaction outstanding.
- Poll: POLL_A/POLL_B each perform one read of cmd_addr (ISSUE/WAIT_ACK sub-sequence). If DQ6 of both reads equal, done, rsp_data_o = second read; else increment poll counter, repeat. Counter reaching POLL_LIMIT → RESP with rsp_err_o=1.
- wb_err_i in any wait: abandon sequence, RESP with rsp_err_o=1 and rsp_data_o=0.
- wb_cyc_o held high from first ISSUE of a command through final ack, including all polls (the downstream bus flushes its queue when cyc drops); low in IDLE and RESP.
- Commands are accepted only in IDLE; no queuing.

## Timing
- Reset values: cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, state IDLE.
- Accept cycle N → wb_cyc_o=wb_stb_o=1 at N+1.
- Ack at cycle M on final step → rsp_valid_o at M+1 for exactly one cycle, cmd_ready_o=1 at M+2.
- wb_stb_o, wb_adr_o, wb_dat_o, wb_we_o stable while wb_stall_i=1.
- ack and err in the same cycle: err wins.
- Ack arriving while stb still asserted (same cycle stall drops) counts for that transaction.
- wb_rst_i mid-sequence: all outputs return to reset values immediately (async); partial device sequence is not recovered — software issues RESET.
- Poll counter width = clog2(POLL_LIMIT+1); compare is ≥, no wrap.

## Structure
- Package nor_cmd_pkg: op codes, unlock addresses (555, 2AA), command bytes (AA, 55, A0, 80, 30, F0), step counts per op, DQ6 bit index.
- Sub-module wb_txn_master: single-transaction wishbone engine (req/we/adr/dat in; done/err/rdata out; stb/stall/ack handling). Sequencer FSM drives it and owns cyc.

## Test plan
- READ addr 0x0001234, slave returns 0xBEEF after 3 stall cycles → one read at 0x0001234, rsp_data_o=0xBEEF, rsp_err_o=0.
- PROGRAM addr 0x10, data 0x5A5A; status reads toggle DQ6 3 times then stable 0x5A5A → writes 555/AA, 2AA/55, 555/A0, 010/5A5A, 8 reads, rsp_data_o=0x5A5A, cyc never dropped.
- SECTOR_ERASE 0x20000 → six writes in exact order ending 20000/30, then poll until stable, rsp_err_o=0.
- PROGRAM with POLL_LIMIT=4 and DQ6 always toggling → 4 read pairs then rsp_err_o=1.
- wb_err_i on second unlock write → no further transactions, rsp_valid_o with rsp_err_o=1, cyc low next cycle.
- Assert wb_rst_i during poll → cyc/stb low same cycle; RESET command afterwards → single write 000/F0, rsp_err_o=0.
